// File: rtl/av2_cdef_block_buffer_if.sv
// Pixel-in / block-out handshake bundle for the CDEF stripe buffer.
// The buffer itself connects through the slave modport; the producer/consumer side uses master.
interface av2_cdef_block_buffer_if #(
  parameter int BLOCK_SIZE = 8
);
  logic [9:0]                          pix_in;
  logic                                pix_valid;
  logic                                pix_ready;
  logic [BLOCK_SIZE*BLOCK_SIZE*10-1:0] blk_data;
  logic [15:0]                         blk_x;
  logic [15:0]                         blk_y;
  logic                                blk_valid;
  logic                                blk_ready;
  logic                                blk_last;
  logic                                blk_flat;

  modport master (
    output pix_in, pix_valid, blk_ready,
    input  pix_ready, blk_data, blk_x, blk_y, blk_valid, blk_last, blk_flat
  );

  modport slave (
    input  pix_in, pix_valid, blk_ready,
    output pix_ready, blk_data, blk_x, blk_y, blk_valid, blk_last, blk_flat
  );
endinterface

// File: rtl/av2_cdef_block_buffer.sv
// Collects BLOCK_SIZE raster rows into a stripe buffer and emits BLOCK_SIZE x BLOCK_SIZE blocks.
// Define AV2_CDEF_BUF_FLAT_DETECT_EN to enable the registered all-pixels-equal flag on blk_flat.
module av2_cdef_block_buffer #(
  parameter int MAX_WIDTH  = 128,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             frame_width,
  input  logic [15:0]             frame_height,
  input  logic                    start,
  output logic                    frame_done,
  output logic                    cfg_err,
  av2_cdef_block_buffer_if.slave  bus
);

  localparam int          NPIX   = BLOCK_SIZE * BLOCK_SIZE;
  localparam int          DW     = NPIX * 10;
  localparam int          RW     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int          CW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [15:0] BS16   = 16'(BLOCK_SIZE);
  localparam logic [15:0] MAXW16 = 16'(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [15:0]       width_r, width_n;
  logic [15:0]       height_r, height_n;
  logic [RW-1:0]     row_r, row_n;
  logic [15:0]       col_r, col_n;
  logic [15:0]       blk_x_r, blk_x_n;
  logic [15:0]       blk_y_r, blk_y_n;
  logic              blk_valid_r, blk_valid_n;
  logic              blk_last_r, blk_last_n;
  logic [DW-1:0]     blk_data_r, blk_data_n;
  logic              frame_done_r, frame_done_n;
  logic              cfg_err_r, cfg_err_n;
  logic              pix_ready_r, pix_ready_n;

  logic              cfg_ok_s;
  logic              pix_xfer_s;
  logic              last_stripe_s;
  logic              load_s;
  logic              load_last_s;
  logic [15:0]       load_x_s;
  logic [15:0]       rd_col_s [BLOCK_SIZE];
  logic [DW-1:0]     load_data_s;

  logic [9:0]        stripe_mem [BLOCK_SIZE][MAX_WIDTH];

  assign cfg_ok_s = (frame_width != 16'd0) && (frame_height != 16'd0)
                 && ((frame_width % BS16) == 16'd0) && ((frame_height % BS16) == 16'd0)
                 && (frame_width <= MAXW16);

  // pix_ready_r mirrors state_r == FILL, so it doubles as the FILL qualifier
  assign pix_xfer_s    = pix_ready_r && bus.pix_valid;
  assign last_stripe_s = ((blk_y_r + BS16) == height_r);
  assign load_x_s      = (state_r == DRAIN) ? (blk_x_r + BS16) : 16'd0;
  assign load_last_s   = last_stripe_s && ((load_x_s + BS16) == width_r);

  // Buffer column addressed by each block column of the block being loaded
  always_comb begin
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      rd_col_s[c] = load_x_s + 16'(c);
    end
  end

  // Gather the next block; the pixel completing the stripe is forwarded past the buffer
  always_comb begin
    load_data_s = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      for (int c = 0; c < BLOCK_SIZE; c++) begin
        if (pix_xfer_s && (row_r == RW'(r)) && (col_r == rd_col_s[c])) begin
          load_data_s[(r*BLOCK_SIZE+c)*10 +: 10] = bus.pix_in;
        end else if (rd_col_s[c] < MAXW16) begin
          load_data_s[(r*BLOCK_SIZE+c)*10 +: 10] = stripe_mem[RW'(r)][rd_col_s[c][CW-1:0]];
        end else begin
          load_data_s[(r*BLOCK_SIZE+c)*10 +: 10] = 10'd0;
        end
      end
    end
  end

  // Stripe buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (pix_xfer_s) begin
      stripe_mem[row_r][col_r[CW-1:0]] <= bus.pix_in;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state_r;
    width_n      = width_r;
    height_n     = height_r;
    row_n        = row_r;
    col_n        = col_r;
    blk_x_n      = blk_x_r;
    blk_y_n      = blk_y_r;
    blk_valid_n  = blk_valid_r;
    blk_last_n   = blk_last_r;
    blk_data_n   = blk_data_r;
    frame_done_n = 1'b0;
    cfg_err_n    = 1'b0;
    load_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_ok_s) begin
            width_n  = frame_width;
            height_n = frame_height;
            row_n    = '0;
            col_n    = 16'd0;
            blk_x_n  = 16'd0;
            blk_y_n  = 16'd0;
            state_n  = FILL;
          end else begin
            cfg_err_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end

      FILL: begin
        if (pix_xfer_s) begin
          if (col_r == (width_r - 16'd1)) begin
            col_n = 16'd0;
            if (row_r == RW'(BLOCK_SIZE - 1)) begin
              row_n       = '0;
              state_n     = DRAIN;
              load_s      = 1'b1;
              blk_valid_n = 1'b1;
              blk_x_n     = 16'd0;
              blk_data_n  = load_data_s;
              blk_last_n  = load_last_s;
            end else begin
              row_n = row_r + RW'(1);
            end
          end else begin
            col_n = col_r + 16'd1;
          end
        end else begin
          state_n = FILL;
        end
      end

      DRAIN: begin
        if (bus.blk_ready) begin
          if ((blk_x_r + BS16) == width_r) begin
            blk_valid_n = 1'b0;
            blk_last_n  = 1'b0;
            if (last_stripe_s) begin
              state_n      = IDLE;
              frame_done_n = 1'b1;
            end else begin
              blk_y_n = blk_y_r + BS16;
              blk_x_n = 16'd0;
              row_n   = '0;
              col_n   = 16'd0;
              state_n = FILL;
            end
          end else begin
            load_s     = 1'b1;
            blk_x_n    = load_x_s;
            blk_data_n = load_data_s;
            blk_last_n = load_last_s;
          end
        end else begin
          state_n = DRAIN;
        end
      end

      default: begin
        state_n     = IDLE;
        blk_valid_n = 1'b0;
        blk_last_n  = 1'b0;
      end
    endcase

    pix_ready_n = (state_n == FILL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      width_r      <= 16'd0;
      height_r     <= 16'd0;
      row_r        <= '0;
      col_r        <= 16'd0;
      blk_x_r      <= 16'd0;
      blk_y_r      <= 16'd0;
      blk_valid_r  <= 1'b0;
      blk_last_r   <= 1'b0;
      blk_data_r   <= '0;
      frame_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      pix_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      width_r      <= width_n;
      height_r     <= height_n;
      row_r        <= row_n;
      col_r        <= col_n;
      blk_x_r      <= blk_x_n;
      blk_y_r      <= blk_y_n;
      blk_valid_r  <= blk_valid_n;
      blk_last_r   <= blk_last_n;
      blk_data_r   <= blk_data_n;
      frame_done_r <= frame_done_n;
      cfg_err_r    <= cfg_err_n;
      pix_ready_r  <= pix_ready_n;
    end
  end

`ifdef AV2_CDEF_BUF_FLAT_DETECT_EN
  logic blk_flat_r;

  function automatic logic all_equal(input logic [DW-1:0] d);
    logic eq;
    eq = 1'b1;
    for (int i = 1; i < NPIX; i++) begin
      if (d[i*10 +: 10] != d[9:0]) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

  // Flat flag is captured with the block data it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_flat_r <= 1'b0;
    end else if (load_s) begin
      blk_flat_r <= all_equal(load_data_s);
    end else if (!blk_valid_n) begin
      blk_flat_r <= 1'b0;
    end else begin
      blk_flat_r <= blk_flat_r;
    end
  end

  assign bus.blk_flat = blk_flat_r;
`else
  assign bus.blk_flat = 1'b0;
`endif

  assign bus.pix_ready = pix_ready_r;
  assign bus.blk_valid = blk_valid_r;
  assign bus.blk_data  = blk_data_r;
  assign bus.blk_x     = blk_x_r;
  assign bus.blk_y     = blk_y_r;
  assign bus.blk_last  = blk_last_r;
  assign frame_done    = frame_done_r;
  assign cfg_err       = cfg_err_r;

endmodule
